hazard_control_unit: RTL
========================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter DIV_LATENCY, default 32: number of cycles a divide occupies the HI/LO unit; legal range 2..63.
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous and active-low.
REQ-004 ID_rs_i, ID_rt_i  input  `R_WIDTH each  source register numbers of the instruction in ID.
REQ-005 ID_branch_i  input  1  the ID instruction is a branch resolved in ID.
REQ-006 ID_branch_taken_i  input  1  branch comparison result; valid only when ID_branch_i=1.
REQ-007 ID_div_start_i  input  1  the ID instruction is a divide.
REQ-008 ID_uses_hilo_i  input  1  the ID instruction reads HI/LO (mfhi/mflo).
REQ-009 EX_rd_i  input  `R_WIDTH  destination register of the instruction in EX.
REQ-010 EX_reg_write_i, EX_mem_read_i  input  1 each  EX writes a register / EX is a load.
REQ-011 MEM_dmem_ready_i  input  1  data memory has completed the MEM-stage access.
REQ-012 PC_write_o  output  1  PC update enable.
REQ-013 IF_ID_write_o  output  1  IF/ID register update enable.
REQ-014 IF_flush_o  output  1  clear IF/ID to a NOP on the next edge.
REQ-015 ID_EX_bubble_o  output  1  load a bubble into ID/EX instead of the ID instruction.
REQ-016 pipe_freeze_o  output  1  hold EX/MEM and MEM/WB; all other enables are also held.
REQ-017 div_busy_o  output  1  divide in progress.

Function
REQ-018 Register 0 never causes a hazard: every match requires a nonzero EX_rd_i.
REQ-019 Load-use: EX_mem_read_i=1 and EX_rd_i matching ID_rs_i or ID_rt_i SHALL cause one stall cycle.
REQ-020 Branch-ALU: ID_branch_i=1, EX_reg_write_i=1, EX_mem_read_i=0 and an rs/rt match SHALL cause one stall cycle.
REQ-021 Branch-load: ID_branch_i=1, EX_mem_read_i=1 and an rs/rt match SHALL cause two consecutive stall cycles.
REQ-022 State machine IDLE, STALL2 with the following transitions:
- IDLE to STALL2 when REQ-021 fires.
- STALL2 to IDLE after one cycle.
- STALL2 forces a stall regardless of the EX inputs.
REQ-023 Stall cycle outputs: PC_write_o=0, IF_ID_write_o=0, ID_EX_bubble_o=1, IF_flush_o=0.
REQ-024 Divide counter, 6 bits:
- ID_div_start_i=1 accepted while not busy and not stalled loads DIV_LATENCY-1 and sets div_busy_o=1 from the next cycle.
- The counter decrements each non-frozen cycle.
- div_busy_o clears the cycle after the counter reaches 0.
REQ-025 While div_busy_o=1, an ID instruction with ID_uses_hilo_i=1 or ID_div_start_i=1 SHALL stall per REQ-023.
REQ-026 Taken branch: ID_branch_i=1, ID_branch_taken_i=1 and no stall SHALL assert IF_flush_o=1 with PC_write_o=1 and IF_ID_write_o=1 for that cycle.
REQ-027 IF_flush_o SHALL NOT assert in any stall or freeze cycle.
REQ-028 Memory freeze: MEM_dmem_ready_i=0 SHALL assert pipe_freeze_o=1 and drive PC_write_o=0, IF_ID_write_o=0, ID_EX_bubble_o=0, IF_flush_o=0.
REQ-029 During a freeze, the FSM state and the divide counter SHALL hold, and no new divide is accepted.
REQ-030 Priority order, highest first: freeze, STALL2, load-use/branch/divide stall, flush, normal.
REQ-031 Normal cycle outputs: PC_write_o=1, IF_ID_write_o=1, all other outputs 0 except div_busy_o.
REQ-032 All outputs are combinational from the registered state and the current inputs; detection adds no latency.

Reset
REQ-033 While rst_n_i=0, the FSM SHALL be IDLE, the counter 0 and div_busy_o=0.
REQ-034 While rst_n_i=0, outputs SHALL be forced to PC_write_o=1, IF_ID_write_o=1, all others 0, regardless of inputs.
REQ-035 Reset asserted mid-STALL2 or mid-divide SHALL abort immediately, with no residual stall after release.

Verification
REQ-036 Load-use: EX_mem_read_i=1, EX_rd_i=8, ID_rs_i=8 for one cycle -> exactly one cycle with PC_write_o=0 and ID_EX_bubble_o=1.
REQ-037 Branch-load: ID_branch_i=1, EX_mem_read_i=1, EX_rd_i=9, ID_rt_i=9 -> two stall cycles, then IF_flush_o=1 on the third cycle if ID_branch_taken_i=1.
REQ-038 Divide: ID_div_start_i=1 with DIV_LATENCY=4, then ID_uses_hilo_i=1 held -> div_busy_o high 4 cycles, stall for those 4 cycles, then normal.
REQ-039 Freeze during divide: MEM_dmem_ready_i=0 for 3 cycles mid-divide -> pipe_freeze_o=1 for those 3 cycles, and div_busy_o extended by 3 cycles.
REQ-040 Register 0: EX_mem_read_i=1, EX_rd_i=0, ID_rs_i=0 -> no stall.
REQ-041 Reset in STALL2: assert rst_n_i asynchronously -> outputs at reset values immediately, and IDLE behaviour after release.

Source files
------------

// File: rtl/hazard_control_unit.sv
`default_nettype none
`ifndef R_WIDTH
`define R_WIDTH 5
`endif
// +------------------------------------------------------------------------+
// | hazard_control_unit: stall/flush/freeze control for a 5-stage pipeline |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module hazard_control_unit #(
  parameter int DIV_LATENCY = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [`R_WIDTH-1:0]  ID_rs_i,
  input  logic [`R_WIDTH-1:0]  ID_rt_i,
  input  logic                 ID_branch_i,
  input  logic                 ID_branch_taken_i,
  input  logic                 ID_div_start_i,
  input  logic                 ID_uses_hilo_i,
  input  logic [`R_WIDTH-1:0]  EX_rd_i,
  input  logic                 EX_reg_write_i,
  input  logic                 EX_mem_read_i,
  input  logic                 MEM_dmem_ready_i,
  output logic                 PC_write_o,
  output logic                 IF_ID_write_o,
  output logic                 IF_flush_o,
  output logic                 ID_EX_bubble_o,
  output logic                 pipe_freeze_o,
  output logic                 div_busy_o
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STALL2 = 1'b1
  } state_t;

  localparam logic [5:0] DIV_LOAD = 6'(DIV_LATENCY - 1);

  state_t     state_q, state_d;
  logic [5:0] div_cnt_q, div_cnt_d;
  logic       div_busy_q, div_busy_d;

  logic any_match;
  logic load_use;
  logic branch_alu;
  logic branch_load;
  logic div_hazard;
  logic freeze;
  logic stall;

  // Register 0 is hardwired, so a zero destination never creates a dependency.
  assign any_match   = (EX_rd_i != '0) && ((EX_rd_i == ID_rs_i) || (EX_rd_i == ID_rt_i));
  assign load_use    = EX_mem_read_i && any_match;
  assign branch_alu  = ID_branch_i && EX_reg_write_i && !EX_mem_read_i && any_match;
  assign branch_load = ID_branch_i && EX_mem_read_i && any_match;
  assign div_hazard  = div_busy_q && (ID_uses_hilo_i || ID_div_start_i);
  assign freeze      = !MEM_dmem_ready_i;
  assign stall       = (state_q == ST_STALL2) || load_use || branch_alu || div_hazard;

  assign div_busy_o  = div_busy_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      div_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      div_busy_q <= div_busy_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    div_cnt_d      = div_cnt_q;
    div_busy_d     = div_busy_q;
    PC_write_o     = 1'b1;
    IF_ID_write_o  = 1'b1;
    IF_flush_o     = 1'b0;
    ID_EX_bubble_o = 1'b0;
    pipe_freeze_o  = 1'b0;

    if (!rst_n_i) begin
      // Outputs stay at their reset values regardless of the inputs.
    end else if (freeze) begin
      pipe_freeze_o = 1'b1;
      PC_write_o    = 1'b0;
      IF_ID_write_o = 1'b0;
    end else begin
      if (stall) begin
        PC_write_o     = 1'b0;
        IF_ID_write_o  = 1'b0;
        ID_EX_bubble_o = 1'b1;
      end else if (ID_branch_i && ID_branch_taken_i) begin
        IF_flush_o = 1'b1;
      end

      // The first branch-load stall is the ordinary load-use stall; STALL2 adds the second.
      state_d = ((state_q == ST_IDLE) && branch_load) ? ST_STALL2 : ST_IDLE;

      if (div_busy_q) begin
        if (div_cnt_q == '0) begin
          div_busy_d = 1'b0;
        end else begin
          div_cnt_d = div_cnt_q - 6'd1;
        end
      end else if (ID_div_start_i && !stall) begin
        div_cnt_d  = DIV_LOAD;
        div_busy_d = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
